// File: rtl/unstripe.sv
// Two-lane to one-stream merger: re-serialises a 2f-held lane pair (lane0 then lane1)
// onto one stream, flags lane-protocol violations and counts emitted words.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | sampling lanes every edge; a valid0 pair emits lane0 now
//  SECOND | emitting the captured lane1 word (or a bubble); lanes ignored
module unstripe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] lane0,
    input  logic [WIDTH-1:0] lane1,
    input  logic             valid0,
    input  logic             valid1,
    output logic [WIDTH-1:0] dataOut,
    output logic             validOut,
    output logic             err,
    output logic [CNT_W-1:0] wordCount
);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold1_q, hold1_d;
    logic             hv1_q, hv1_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             emit;

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q <= IDLE;
            hold1_q <= '0;
            hv1_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold1_q <= hold1_d;
            hv1_q   <= hv1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // data_d stays zero unless a word is emitted, so the output never shows stale data
    always_comb begin
        state_d = state_q;
        hold1_d = hold1_q;
        hv1_d   = hv1_q;
        data_d  = '0;
        valid_d = 1'b0;
        err_d   = err_q;
        emit    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid0) begin
                    hold1_d = lane1;
                    hv1_d   = valid1;
                    data_d  = lane0;
                    valid_d = 1'b1;
                    emit    = 1'b1;
                    state_d = SECOND;
                end else if (valid1) begin
                    err_d = 1'b1;
                end
            end
            SECOND: begin
                state_d = IDLE;
                if (hv1_q) begin
                    data_d  = hold1_q;
                    valid_d = 1'b1;
                    emit    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q;
        if (emit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign dataOut   = data_q;
    assign validOut  = valid_q;
    assign err       = err_q;
    assign wordCount = cnt_q;

endmodule

// File: tb/tb_unstripe.sv
// Randomised bench for unstripe: a queue-based model of the expected output stream,
// with a second instance at CNT_W=4 to exercise counter saturation.
module tb_unstripe;

    localparam int WIDTH = 32;

    logic             clk_2f = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] lane0, lane1;
    logic             valid0, valid1;
    logic [WIDTH-1:0] dataOut, dataOut_s;
    logic             validOut, validOut_s;
    logic             err, err_s;
    logic [15:0]      wordCount;
    logic [3:0]       wordCount_s;

    int n_cmp = 0;
    int n_bad = 0;

    unstripe #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk_2f(clk_2f), .reset(reset),
        .lane0(lane0), .lane1(lane1), .valid0(valid0), .valid1(valid1),
        .dataOut(dataOut), .validOut(validOut), .err(err), .wordCount(wordCount)
    );

    unstripe #(.WIDTH(WIDTH), .CNT_W(4)) dut_s (
        .clk_2f(clk_2f), .reset(reset),
        .lane0(lane0), .lane1(lane1), .valid0(valid0), .valid1(valid1),
        .dataOut(dataOut_s), .validOut(validOut_s), .err(err_s), .wordCount(wordCount_s)
    );

    always #5 clk_2f = ~clk_2f;

    // Reference: words still owed to the stream from an accepted pair, as {valid, data}.
    logic [WIDTH:0]   owed_q[$];
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
    logic             exp_err;
    int               exp_cnt;
    int               exp_cnt_s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [WIDTH:0] s;
        if (reset) begin
            owed_q.delete();
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            exp_cnt   = 0;
            exp_cnt_s = 0;
        end else begin
            if (owed_q.size() > 0) begin
                s         = owed_q.pop_front();
                exp_valid = s[WIDTH];
                exp_data  = s[WIDTH] ? s[WIDTH-1:0] : '0;
            end else if (valid0) begin
                exp_valid = 1'b1;
                exp_data  = lane0;
                owed_q.push_back({valid1, valid1 ? lane1 : {WIDTH{1'b0}}});
            end else begin
                exp_valid = 1'b0;
                exp_data  = '0;
                if (valid1) exp_err = 1'b1;
            end
            if (exp_valid) begin
                exp_cnt   = (exp_cnt   < 65535) ? exp_cnt + 1   : exp_cnt;
                exp_cnt_s = (exp_cnt_s < 15)    ? exp_cnt_s + 1 : exp_cnt_s;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_2f);
        model_edge();
        #1;
        chk("dataOut",   64'(dataOut),     64'(exp_data));
        chk("validOut",  64'(validOut),    64'(exp_valid));
        chk("err",       64'(err),         64'(exp_err));
        chk("wordCount", 64'(wordCount),   64'(exp_cnt));
        chk("wcount_s",  64'(wordCount_s), 64'(exp_cnt_s));
        chk("data_s",    64'(dataOut_s),   64'(exp_data));
    endtask

    task automatic drive(input logic v0, input logic v1,
                         input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        valid0 = v0; valid1 = v1; lane0 = d0; lane1 = d1;
    endtask

    task automatic pair(input logic v0, input logic v1,
                        input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        drive(v0, v1, d0, d1);
        step();
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        owed_q.delete();
        exp_data = '0; exp_valid = 1'b0; exp_err = 1'b0; exp_cnt = 0; exp_cnt_s = 0;

        do_reset();
        for (int i = 0; i < 4; i++) step();

        pair(1'b1, 1'b1, 32'hA000_0000, 32'hA000_0001);
        chk("A0_first", 64'(dataOut), 64'h0000_0000_A000_0001);
        pair(1'b1, 1'b1, 32'hB000_0000, 32'hB000_0001);
        chk("four_words", 64'(wordCount), 64'd4);
        drive(1'b0, 1'b0, '0, '0);
        step();

        do_reset();
        pair(1'b1, 1'b0, 32'hC000_0000, 32'hC000_0001);
        drive(1'b0, 1'b0, '0, '0);
        step();
        chk("odd_tail_cnt", 64'(wordCount), 64'd1);

        drive(1'b0, 1'b1, '0, 32'hDEAD_BEEF);
        step();
        chk("err_set", 64'(err), 64'd1);
        drive(1'b0, 1'b0, '0, '0);
        step();
        pair(1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222);
        chk("err_sticky", 64'(err), 64'd1);

        do_reset();
        drive(1'b1, 1'b1, 32'hD000_0000, 32'hD000_0001);
        step();
        chk("D0_out", 64'(dataOut), 64'h0000_0000_D000_0000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) step();
        chk("D1_dropped", 64'(validOut), 64'd0);

        do_reset();
        for (int i = 0; i < 10; i++) pair(1'b1, 1'b1, $urandom, $urandom);
        chk("sat15", 64'(wordCount_s), 64'd15);
        chk("cnt20", 64'(wordCount), 64'd20);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            int k;
            k = int'($urandom_range(0, 99));
            if (k < 50)      pair(1'b1, 1'b1, $urandom, $urandom);
            else if (k < 62) pair(1'b1, 1'b0, $urandom, $urandom);
            else if (k < 80) begin drive(1'b0, 1'b0, $urandom, $urandom); step(); end
            else if (k < 90) begin
                drive(1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom);
                step();
                drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom);
                step();
            end
            else if (k < 93) begin drive(1'b0, 1'b1, $urandom, $urandom); step(); end
            else if (k < 95) do_reset();
            else begin drive(1'b1, 1'b1, $urandom, $urandom); step(); end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/unstripe.md
# unstripe

Two-lane to one-stream merger at the receive end of the two-lane link. It runs at 2f: each clk_2f cycle it samples a lane pair (lane0, lane1, valid0, valid1), which the upstream holds stable for two clk_2f cycles. It then re-serialises the pair onto a single WIDTH-bit output stream in order: lane0 word first, lane1 word second. It also flags lane-protocol violations and counts merged words for the link monitor.

## Interface
- WIDTH, 32, data width of each lane and of dataOut
- CNT_W, 16, width of the merged-word counter
- clk_2f  input  1  2f clock; all logic on its rising edge
- reset  input  1  synchronous, active-high; clock clk_2f
- lane0  input  WIDTH  even-position word of the current pair
- lane1  input  WIDTH  odd-position word of the current pair
- valid0  input  1  lane0 holds a valid word
- valid1  input  1  lane1 holds a valid word
- dataOut  output  WIDTH  merged stream, registered
- validOut  output  1  dataOut is valid this cycle, registered
- err  output  1  sticky lane-protocol error, registered
- wordCount  output  CNT_W  number of words emitted since reset, saturating, registered

## Operation
- FSM has two states: IDLE (sampling) and SECOND (emitting the second word of a captured pair).
- IDLE, valid0=1:
  - capture lane1 into hold1 and valid1 into hv1;
  - register dataOut=lane0, validOut=1, wordCount+1;
  - go to SECOND.
- IDLE, valid0=0, valid1=0: dataOut=0, validOut=0; stay in IDLE.
- IDLE, valid0=0, valid1=1 (protocol violation):
  - set err=1;
  - dataOut=0, validOut=0;
  - nothing is captured; stay in IDLE.
- SECOND: lane inputs are ignored; go to IDLE unconditionally.
  - hv1=1: register dataOut=hold1, validOut=1, wordCount+1.
  - hv1=0 (tail of an odd-length burst): dataOut=0, validOut=0.
- dataOut is forced to 0 whenever validOut=0. It never shows stale data.
- Alignment: the first edge in IDLE that samples valid0=1 fixes the pair phase. Back-to-back pairs alternate IDLE/SECOND with no bubble. A burst gap re-aligns the block, because IDLE samples every cycle.
- err is cleared only by reset.
- wordCount saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Reset values (the edge after reset is sampled high):
  - dataOut=0, validOut=0, err=0, wordCount=0;
  - state=IDLE, hold1=0, hv1=0.
- Reset mid-pair, while in SECOND: the pending lane1 word is discarded and is not emitted.
- Latency: sampling edge E emits lane0 after E and lane1 after E+1.
- Throughput: 1 word per clk_2f cycle while both lanes are valid.
- Upstream contract: a pair is stable across edges E and E+1, and the next pair is presented at E+2. A pair change at E+1 is not detected and is dropped.
- validOut is high for at most 2 consecutive cycles per pair. For continuous full pairs it is high every cycle.

## Test plan
- Reset, then idle inputs -> dataOut=0, validOut=0, err=0, wordCount=0 on every cycle.
- Pairs (A0,A1), (B0,B1) with valid0=valid1=1, each held 2 cycles -> dataOut=A0,A1,B0,B1 on 4 consecutive cycles, validOut=1 throughout, wordCount=4.
- Pair (C0,C1) held with valid0=1, valid1=0, then idle -> dataOut=C0 for one cycle, then validOut=0, dataOut=0; wordCount=1.
- valid0=0, valid1=1, lane1=0xDEADBEEF in IDLE -> err=1 from the next cycle and stays high; validOut stays 0. Later valid pairs still merge correctly.
- reset asserted in the SECOND cycle of pair (D0,D1) -> D0 is emitted, D1 never appears; all outputs are 0 after the reset edge.
- CNT_W=4 with 20 continuous full-pair words -> wordCount stops at 15 and does not wrap.
